// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported, fixed-latency memory between the fetch port and the data port.
// Data wins ties; a defer counter forces a fetch grant after MAX_DEFER consecutive bypasses.
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 2,
  parameter int MAX_DEFER = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [2:0]           dbg_state,
  output logic [3:0]           dbg_defer
);

  // Handshake: a requester raises its request and holds it (with address/data) until its ready
  // pulses for one cycle; the request is dropped during that ready cycle, when it is not sampled.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [3:0] MAX_D  = 4'(MAX_DEFER);

  state_t     state, state_nxt;
  logic [3:0] cycle_cnt;
  logic [3:0] defer_cnt, defer_nxt;
  logic       d_pend, f_pend;
  logic       grant_i, grant_d;
  logic       done_i, done_d;

  // The side that just finished is ignored while it drops its request.
  assign d_pend = (d_read | d_write) && (state != DONE_D);
  assign f_pend = i_req && (state != DONE_I);

  always_comb begin
    state_nxt = state;
    defer_nxt = defer_cnt;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done_i    = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE, DONE_I, DONE_D: begin
        if (d_pend && f_pend && (defer_cnt == MAX_D)) begin
          grant_i   = 1'b1;
          defer_nxt = 4'd0;
          state_nxt = BUSY_I;
        end else if (d_pend) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
          if (f_pend)
            defer_nxt = (defer_cnt == 4'hF) ? defer_cnt : defer_cnt + 4'd1;
          else
            defer_nxt = 4'd0;
        end else if (f_pend) begin
          grant_i   = 1'b1;
          defer_nxt = 4'd0;
          state_nxt = BUSY_I;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY_I: begin
        if (cycle_cnt == 4'd0) begin
          done_i    = 1'b1;
          state_nxt = DONE_I;
        end
      end
      BUSY_D: begin
        if (cycle_cnt == 4'd0) begin
          done_d    = 1'b1;
          state_nxt = DONE_D;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state     <= IDLE;
      defer_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      defer_cnt <= defer_nxt;
    end
  end

  // Memory-side signals are latched at the grant edge and held for the whole access.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      cycle_cnt <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        cycle_cnt <= LAT_M1;
      end else if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_write;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        cycle_cnt <= LAT_M1;
      end else if (done_i) begin
        mem_req <= 1'b0;
        i_rdata <= mem_rdata;
        i_ready <= 1'b1;
      end else if (done_d) begin
        mem_req <= 1'b0;
        if (!mem_we)
          d_rdata <= mem_rdata;
        d_ready <= 1'b1;
      end else if ((state == BUSY_I) || (state == BUSY_D)) begin
        cycle_cnt <= cycle_cnt - 4'd1;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_defer = defer_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: linear stimulus, a ready-side monitor popping an
// expected-result queue, and latency/stability checks on the memory port.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int LAT = 2;

  logic         Clk;
  logic         Reset_N;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic [W-1:0] i_rdata;
  logic         i_ready;
  logic         d_read;
  logic         d_write;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic [W-1:0] d_rdata;
  logic         d_ready;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata;
  logic [2:0]   dbg_state;
  logic [3:0]   dbg_defer;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] exp_d_rdata;

  mem_port_arbiter #(.WORD_SIZE(W), .LATENCY(LAT), .MAX_DEFER(4)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_defer(dbg_defer)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Memory contents as seen through the read port
  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
    if (a == 16'h0010) return 16'hB123;
    return a ^ 16'hC35A;
  endfunction
  assign mem_rdata = mem_fn(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Waits for the given side's ready pulse, counting cycles with mem_req high.
  task automatic wait_ready(input string tag, input bit data_side, output int req_cyc);
    int n;
    req_cyc = mem_req ? 1 : 0;
    n = 0;
    do begin
      tick();
      if (mem_req) req_cyc++;
      n++;
    end while (!(data_side ? d_ready : i_ready) && n < 40);
    chk({tag, "_ready_seen"}, {31'd0, data_side ? d_ready : i_ready}, 32'd1);
  endtask

  task automatic push_fetch(input logic [W-1:0] a);
    exp_q.push_back({1'b0, mem_fn(a)});
  endtask

  task automatic push_data(input bit is_write, input logic [W-1:0] a);
    if (!is_write) exp_d_rdata = mem_fn(a);
    exp_q.push_back({1'b1, exp_d_rdata});
  endtask

  // Scoreboard: every ready pulse pops one expected completion
  always @(negedge Clk) begin
    if (Reset_N && (i_ready || d_ready)) begin
      chk("ready_exclusive", {31'd0, i_ready & d_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_ready", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("ready_side", {31'd0, d_ready}, {31'd0, e[W]});
        if (d_ready) chk("d_rdata", {16'd0, d_rdata}, {16'd0, e[W-1:0]});
        else         chk("i_rdata", {16'd0, i_rdata}, {16'd0, e[W-1:0]});
      end
    end
  end

  initial begin
    int rc;
    int cyc_d;
    int cyc_i;
    exp_d_rdata = '0;
    Reset_N = 1'b0; i_req = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    Reset_N = 1'b1;
    tick();

    // Isolated fetch
    i_req = 1'b1; i_addr = 16'h0010; push_fetch(16'h0010);
    tick();
    chk("fetch_grant_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_addr", {16'd0, mem_addr}, 32'h0010);
    chk("fetch_we", {31'd0, mem_we}, 32'd0);
    chk("fetch_state", {29'd0, dbg_state}, 32'd1);
    wait_ready("fetch", 1'b0, rc);
    i_req = 1'b0;
    chk("fetch_req_cycles", rc, LAT);
    chk("fetch_rdata", {16'd0, i_rdata}, 32'hB123);
    tick();
    chk("fetch_ready_pulse", {31'd0, i_ready}, 32'd0);

    // Data read, then write leaves d_rdata alone
    d_read = 1'b1; d_addr = 16'h0123; push_data(1'b0, 16'h0123);
    wait_ready("dread", 1'b1, rc);
    d_read = 1'b0;
    chk("dread_req_cycles", rc, LAT);
    tick();
    d_write = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5A5A; push_data(1'b1, 16'h0040);
    tick();
    chk("dwrite_we", {31'd0, mem_we}, 32'd1);
    chk("dwrite_wdata", {16'd0, mem_wdata}, 32'h5A5A);
    chk("dwrite_addr", {16'd0, mem_addr}, 32'h0040);
    tick();
    chk("dwrite_we_hold", {31'd0, mem_we}, 32'd1);
    chk("dwrite_wdata_hold", {16'd0, mem_wdata}, 32'h5A5A);
    wait_ready("dwrite", 1'b1, rc);
    d_write = 1'b0;
    chk("dwrite_req_cycles", rc, 1);
    tick();

    // Simultaneous fetch and data read: data first, fetch from DONE_D
    i_req = 1'b1; i_addr = 16'h0200; d_read = 1'b1; d_addr = 16'h0300;
    push_data(1'b0, 16'h0300); push_fetch(16'h0200);
    wait_ready("sim_d", 1'b1, rc);
    cyc_d = cyc;
    d_read = 1'b0;
    chk("sim_defer_after_d", {28'd0, dbg_defer}, 32'd1);
    wait_ready("sim_i", 1'b0, rc);
    cyc_i = cyc;
    i_req = 1'b0;
    chk("sim_i_req_cycles", rc, LAT);
    chk("sim_ready_gap", cyc_i - cyc_d, LAT + 1);
    chk("sim_defer_cleared", {28'd0, dbg_defer}, 32'd0);
    tick();

    // Defer counter: fetch repeatedly loses to data (withdrawing after each loss)
    for (int k = 0; k < 4; k++) begin
      i_req = 1'b1; i_addr = 16'h0400; d_read = 1'b1; d_addr = 16'h0A00 + 16'(k);
      push_data(1'b0, 16'h0A00 + 16'(k));
      tick();
      chk("defer_data_grant", {16'd0, mem_addr}, {16'd0, 16'h0A00 + 16'(k)});
      chk("defer_count", {28'd0, dbg_defer}, k + 1);
      i_req = 1'b0;
      wait_ready("defer_d", 1'b1, rc);
      d_read = 1'b0;
      tick();
    end
    i_req = 1'b1; i_addr = 16'h0400; d_read = 1'b1; d_addr = 16'h0B00;
    push_fetch(16'h0400); push_data(1'b0, 16'h0B00);
    tick();
    chk("forced_fetch_addr", {16'd0, mem_addr}, 32'h0400);
    chk("forced_fetch_state", {29'd0, dbg_state}, 32'd1);
    chk("forced_defer_clear", {28'd0, dbg_defer}, 32'd0);
    wait_ready("forced_i", 1'b0, rc);
    i_req = 1'b0;
    wait_ready("after_forced_d", 1'b1, rc);
    d_read = 1'b0;
    tick();

    // Address change mid-access
    d_read = 1'b1; d_addr = 16'h0500; push_data(1'b0, 16'h0500);
    tick();
    d_addr = 16'h0777;
    tick();
    chk("addr_hold", {16'd0, mem_addr}, 32'h0500);
    wait_ready("addr_hold", 1'b1, rc);
    d_read = 1'b0;
    tick();

    // Reset during the second BUSY_D cycle
    d_write = 1'b1; d_addr = 16'h0600; d_wdata = 16'h1234;
    tick();
    tick();
    chk("pre_rst_busy", {29'd0, dbg_state}, 32'd2);
    Reset_N = 1'b0;
    tick();
    chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_outs", {mem_addr, mem_wdata}, 32'd0);
    chk("mid_rst_rdata", {i_rdata, d_rdata}, 32'd0);
    chk("mid_rst_flags", {29'd0, mem_we, i_ready, d_ready}, 32'd0);
    chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    d_write = 1'b0; Reset_N = 1'b1; exp_d_rdata = '0;
    tick();
    chk("no_ready_after_rst", {30'd0, i_ready, d_ready}, 32'd0);
    i_req = 1'b1; i_addr = 16'h0010; push_fetch(16'h0010);
    wait_ready("post_rst_fetch", 1'b0, rc);
    i_req = 1'b0;
    chk("post_rst_req_cycles", rc, LAT);
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
